uart_rx_64: RTL
===============

Name: uart_rx_64

Overview:
- Receive side of the 64-bit UART link: deserialises eight consecutive 8N1 UART bytes on uart_rxd into one 64-bit word.
- Pulses data_out_done when the word is complete.
- Pairs with the 64-bit UART transmitter inside the top-level; instantiated per clock domain (40 MHz or 60 MHz) with matching parameters.
- Adds framing-error and inter-byte-timeout detection so a corrupted or partial word is never presented as valid.

Parameters:
- CLK_F, 40_000_000, system clock frequency in Hz
- UART_BPS, 115200, line baud rate
- CLK_GOAL, CLK_F/UART_BPS, clocks per bit (347 @40 MHz, 520 @60 MHz)
- TIMEOUT_BITS, 20, idle bit-times after which a partially received word is discarded

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous reset, active-high
- uart_rxd  input  1  serial line, idle high, asynchronous to clk
- data_out_64  output  64  last completed word; first received byte in [63:56], last in [7:0]
- data_out_done  output  1  one-cycle pulse, data_out_64 valid from the same cycle
- frame_err  output  1  one-cycle pulse on bad stop bit
- timeout_err  output  1  one-cycle pulse when a partial word is dropped
- busy  output  1  high whenever the FSM is not in IDLE or byte_idx != 0

Behaviour:
- Design rules: single clock domain; every flop is reset asynchronously by rst.
- Reset values:
  - data_out_64 = 0; data_out_done, frame_err and timeout_err = 0; busy = 0.
  - Synchroniser flops = 1; FSM = IDLE; byte_idx = 0; bit_cnt = 0; baud counter = 0.
- Input sync: 2-flop synchroniser on uart_rxd, then one more flop for edge detect. All sampling uses the synchronised value.
- IDLE:
  - A falling edge (prev = 1, cur = 0) clears the baud counter and enters START.
- START:
  - Count to CLK_GOAL/2 - 1, then sample.
  - Sample 0: go to DATA with the baud counter cleared and bit_cnt = 0.
  - Sample 1: glitch; return to IDLE without error.
- DATA:
  - Each time the baud counter reaches CLK_GOAL - 1, sample one bit and shift it into a byte register, LSB first (bit 0 received first).
  - After 8 bits, go to STOP.
- STOP:
  - Sample at CLK_GOAL - 1.
  - Sample 1: the byte is accepted and the FSM returns to IDLE immediately (supports back-to-back bytes, no extra idle).
  - Sample 0: pulse frame_err, discard the partial word (byte_idx = 0), go to WAIT_IDLE.
- WAIT_IDLE:
  - Stay until the synchronised line has been 1 for CLK_GOAL consecutive cycles, then go to IDLE.
- Byte accept:
  - The word shift register shifts left 8 and inserts the byte at [7:0]; byte_idx increments.
  - When byte_idx was 7, in the cycle after the stop-bit sample: data_out_64 is loaded with the full word and data_out_done pulses. byte_idx wraps to 0.
  - data_out_64 holds its value until the next complete word.
- Timeout:
  - While byte_idx != 0 and the FSM is in IDLE, a counter runs; it is cleared on entry to START.
  - Reaching TIMEOUT_BITS*CLK_GOAL: pulse timeout_err, byte_idx = 0, word register cleared.
  - data_out_64 is unchanged.
- Simultaneous events:
  - A falling edge in the same cycle as timeout expiry: the timeout wins (pulse, clear), and the edge still starts a new byte as byte 0.
- Reset mid-frame: everything returns to reset values immediately; the partial word is lost and no pulse is produced.
- Counter widths: the baud counter is $clog2(CLK_GOAL) bits; the timeout counter is $clog2(TIMEOUT_BITS*CLK_GOAL+1) bits. Neither may overflow.
- The three pulse outputs are mutually exclusive in any cycle.

Test Plan:
- 40 MHz, CLK_GOAL = 347; drive the 8 bytes 9c dd b2 b4 c4 31 1d e1 back-to-back, LSB-first 8N1 -> one data_out_done pulse; data_out_64 = 64'h9cddb2b4c4311de1; no error pulses.
- 60 MHz, CLK_GOAL = 520; send 64'h33e22893d059fe6f then 64'h1c1624f290daa4cb -> two done pulses with the respective values. The first value is held until the second done.
- Low glitch of 100 ns on the idle line -> no state change beyond START; busy returns to 0; no pulses.
- Stop bit forced 0 on byte 3 -> frame_err pulse, no done. A following clean 8-byte word 64'h0123456789abcdef -> done with that exact value.
- Send 3 bytes, then idle 20 bit-times -> timeout_err pulse once; data_out_64 unchanged. A next full word is received correctly.
- Assert rst during byte 5 data bits -> all outputs 0 immediately. After release, a full word 64'hffffffff00000000 -> correct done.

Source files
------------

// File: rtl/uart_rx_64.sv
// rtl/uart_rx_64.sv - 8N1 UART receiver that assembles eight bytes into one 64-bit word
// Flags bad stop bits and drops partial words left idle too long.
module uart_rx_64 #(
   parameter int CLK_F        = 40_000_000,
   parameter int UART_BPS     = 115200,
   parameter int CLK_GOAL     = CLK_F / UART_BPS,
   parameter int TIMEOUT_BITS = 20
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        uart_rxd,
   output logic [63:0] data_out_64,
   output logic        data_out_done,
   output logic        frame_err,
   output logic        timeout_err,
   output logic        busy
);

   localparam int BW       = $clog2(CLK_GOAL);
   localparam int TO_LIMIT = TIMEOUT_BITS * CLK_GOAL;
   localparam int TW       = $clog2(TO_LIMIT + 1);

   localparam logic [BW-1:0] BAUD_LAST = BW'(CLK_GOAL - 1);
   localparam logic [BW-1:0] BAUD_HALF = BW'(CLK_GOAL / 2 - 1);
   localparam logic [TW-1:0] TO_LAST   = TW'(TO_LIMIT);

   typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;

   state_t          state, state_n;
   logic            sync1, sync2, sync3;
   logic            rxd_s, fall;
   logic [BW-1:0]   baud_cnt, baud_n;
   logic [2:0]      bit_cnt, bit_n;
   logic            shift_en, byte_ok, byte_bad;
   logic [7:0]      rx_byte;
   logic [2:0]      byte_idx;
   logic [55:0]     word_reg;
   logic [TW-1:0]   to_cnt;
   logic            to_fire;

   // sync2 is the clean line value; sync3 only serves edge detection
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1 <= 1'b1;
         sync2 <= 1'b1;
         sync3 <= 1'b1;
      end else begin
         sync1 <= uart_rxd;
         sync2 <= sync1;
         sync3 <= sync2;
      end
   end

   assign rxd_s = sync2;
   assign fall  = sync3 & ~sync2;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         baud_cnt <= '0;
         bit_cnt  <= '0;
      end else begin
         state    <= state_n;
         baud_cnt <= baud_n;
         bit_cnt  <= bit_n;
      end
   end

   always_comb begin
      state_n  = state;
      baud_n   = baud_cnt;
      bit_n    = bit_cnt;
      shift_en = 1'b0;
      byte_ok  = 1'b0;
      byte_bad = 1'b0;
      case (state)
         IDLE: begin
            if (fall) begin
               state_n = START;
               baud_n  = '0;
            end
         end
         START: begin
            if (baud_cnt == BAUD_HALF) begin
               baud_n  = '0;
               bit_n   = '0;
               state_n = rxd_s ? IDLE : DATA;
            end else begin
               baud_n = baud_cnt + BW'(1);
            end
         end
         DATA: begin
            if (baud_cnt == BAUD_LAST) begin
               baud_n   = '0;
               shift_en = 1'b1;
               bit_n    = bit_cnt + 3'd1;
               if (bit_cnt == 3'd7) state_n = STOP;
            end else begin
               baud_n = baud_cnt + BW'(1);
            end
         end
         STOP: begin
            // Return straight to IDLE so a back-to-back start bit is not missed
            if (baud_cnt == BAUD_LAST) begin
               baud_n = '0;
               if (rxd_s) begin
                  byte_ok = 1'b1;
                  state_n = IDLE;
               end else begin
                  byte_bad = 1'b1;
                  state_n  = WAIT_IDLE;
               end
            end else begin
               baud_n = baud_cnt + BW'(1);
            end
         end
         WAIT_IDLE: begin
            if (!rxd_s) begin
               baud_n = '0;
            end else if (baud_cnt == BAUD_LAST) begin
               baud_n  = '0;
               state_n = IDLE;
            end else begin
               baud_n = baud_cnt + BW'(1);
            end
         end
         default: state_n = IDLE;
      endcase
   end

   assign to_fire = (state == IDLE) && (byte_idx != 3'd0) && (to_cnt == TO_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_byte       <= '0;
         byte_idx      <= '0;
         word_reg      <= '0;
         to_cnt        <= '0;
         data_out_64   <= '0;
         data_out_done <= 1'b0;
         frame_err     <= 1'b0;
         timeout_err   <= 1'b0;
      end else begin
         data_out_done <= 1'b0;
         frame_err     <= 1'b0;
         timeout_err   <= 1'b0;

         if (shift_en) rx_byte <= {rxd_s, rx_byte[7:1]};

         if (state != IDLE || byte_idx == 3'd0 || to_fire) to_cnt <= '0;
         else                                            to_cnt <= to_cnt + TW'(1);

         // Timeout only fires in IDLE, byte_ok/byte_bad only in STOP: never together
         if (to_fire) begin
            timeout_err <= 1'b1;
            byte_idx    <= '0;
            word_reg    <= '0;
         end else if (byte_ok) begin
            if (byte_idx == 3'd7) begin
               data_out_64   <= {word_reg, rx_byte};
               data_out_done <= 1'b1;
            end
            word_reg <= {word_reg[47:0], rx_byte};
            byte_idx <= byte_idx + 3'd1;
         end else if (byte_bad) begin
            frame_err <= 1'b1;
            byte_idx  <= '0;
            word_reg  <= '0;
         end
      end
   end

   assign busy = (state != IDLE) || (byte_idx != 3'd0);

endmodule
